// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    // Transaction phase of the shared port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Which requester owns the current transaction.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Byte-enable width of the bus and the data requester.
    localparam int WSTRB_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one instruction/data memory port between the fetch unit and the
// memory-access unit. One transaction at a time on a req/gnt/rvalid bus,
// data-first arbitration with a starvation guard for fetch, a wait-state
// timeout, and discard of fetch responses killed by a branch redirect.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               CLK,
    input  logic               RST,
    // fetch requester
    input  logic               if_req,
    input  logic [XLEN-1:0]    if_addr,
    input  logic               if_kill,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_rdata,
    // data requester
    input  logic               d_req,
    input  logic               d_we,
    input  logic [XLEN-1:0]    d_addr,
    input  logic [XLEN-1:0]    d_wdata,
    input  logic [WSTRB_W-1:0] d_wstrb,
    output logic               d_valid,
    output logic [XLEN-1:0]    d_rdata,
    // hazard control
    output logic               stall_f,
    output logic               stall_m,
    output logic               err,
    // memory bus
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [WSTRB_W-1:0] mem_wstrb,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata
);

    // A zero-width counter is not legal, so both counters keep at least one bit.
    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [WC_W-1:0] WAIT_LIM   = WC_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               owner_q;
    logic               we_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [WSTRB_W-1:0] wstrb_q;
    logic [SC_W-1:0]    starve_q;
    logic [WC_W-1:0]    wait_q;
    logic               discard_q;

    logic grant;
    logic grant_owner;
    logic in_wait;
    logic timeout;
    logic done;
    logic fetch_owns;

    // Arbitration decision and transaction-completion conditions.
    always_comb begin
        grant       = (state_q == IDLE) && (if_req || d_req);
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        grant_owner = (if_req && (!d_req || starve_q == STARVE_LIM)) ? OWN_IF : OWN_D;
        in_wait     = (state_q == WAIT);
        // A response arriving on the last allowed cycle still counts as a response.
        timeout     = in_wait && !mem_rvalid && (wait_q == WAIT_LIM);
        done        = in_wait && (mem_rvalid || timeout);
        fetch_owns  = (state_q != IDLE) && (owner_q == OWN_IF);
    end

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)   state_d = REQ;
            REQ:     if (mem_gnt) state_d = WAIT;
            WAIT:    if (done)    state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Latch the winner's request so the bus fields stay stable while mem_req is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (grant) begin
            owner_q <= grant_owner;
            if (grant_owner == OWN_D) begin
                we_q    <= d_we;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                // Reads never carry byte enables onto the bus.
                wstrb_q <= d_we ? d_wstrb : '0;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= if_addr;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    // Count consecutive data grants that left a fetch waiting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_q <= '0;
        end else if (grant) begin
            if (grant_owner == OWN_IF || !if_req) starve_q <= '0;
            else if (starve_q != STARVE_LIM)      starve_q <= starve_q + 1'b1;
        end
    end

    // Wait-state counter: zeroed on entry to WAIT, advances each WAIT cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                            wait_q <= '0;
        else if (state_q == REQ && mem_gnt)  wait_q <= '0;
        else if (in_wait)                    wait_q <= wait_q + 1'b1;
    end

    // Remember a redirect that hit the in-flight fetch; the bus cycle still finishes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                       discard_q <= 1'b0;
        else if (done)                  discard_q <= 1'b0;
        else if (fetch_owns && if_kill) discard_q <= 1'b1;
    end

    // Response strobes, read data, stalls and bus drive.
    always_comb begin
        // A kill in the completion cycle itself also drops the response.
        if_valid  = done && (owner_q == OWN_IF) && !discard_q && !if_kill;
        d_valid   = done && (owner_q == OWN_D);
        // Timeout strobes carry zero data; idle strobes never leak bus data.
        if_rdata  = (if_valid && mem_rvalid) ? mem_rdata : '0;
        d_rdata   = (d_valid && mem_rvalid) ? mem_rdata : '0;
        err       = timeout;
        // Stalls come straight from the requests, so gate them with reset.
        stall_f   = RST && if_req && !if_valid;
        stall_m   = RST && d_req && !d_valid;
        mem_req   = (state_q == REQ);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
    end

endmodule
